// File: rtl/fft_pkg.sv
// Shared constants, state encoding and index helper for the 8-point FFT engine.
package fft_pkg;

  localparam int DW    = 12;      // sample / bin / twiddle width
  localparam int N     = 8;       // transform size (fixed)
  localparam int LOG2N = 3;       // butterfly stages
  localparam int TW_SH = 7;       // twiddle fraction bits (127 ~ 1.0)
  localparam int PW    = 2 * DW;  // full product width

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } state_e;

  // Decimation-in-time input ordering: reverse the three address bits.
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft_bfly_1.sv
// Radix-2 butterfly: products of b*w registered on en_i (read phase),
// then add/sub and halve combinationally for the write phase.
module fft_bfly_1
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [DW-1:0] w_re_i,
  input  logic signed [DW-1:0] w_im_i,
  output logic signed [DW-1:0] top_re_o,
  output logic signed [DW-1:0] top_im_o,
  output logic signed [DW-1:0] bot_re_o,
  output logic signed [DW-1:0] bot_im_o
);

  localparam int XW = PW + 1;  // product sum/difference width
  localparam int SW = DW + 1;  // butterfly sum width

  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [DW-1:0] a_re_q, a_im_q;
  logic signed [SW-1:0] t_re, t_im;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;

  // Capture the four partial products and the top operand during the read phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
      a_re_q <= '0;
      a_im_q <= '0;
    end else if (en_i) begin
      p_rr_q <= PW'(b_re_i) * PW'(w_re_i);
      p_ii_q <= PW'(b_im_i) * PW'(w_im_i);
      p_ri_q <= PW'(b_re_i) * PW'(w_im_i);
      p_ir_q <= PW'(b_im_i) * PW'(w_re_i);
      a_re_q <= a_re_i;
      a_im_q <= a_im_i;
    end
  end

  // Twiddled bottom operand: floor shift by the fraction bits, kept to DW+1 bits
  assign t_re = SW'((XW'(p_rr_q) - XW'(p_ii_q)) >>> TW_SH);
  assign t_im = SW'((XW'(p_ri_q) + XW'(p_ir_q)) >>> TW_SH);

  // Sums wrap in DW+1 bits; halving keeps growth bounded (no saturation)
  assign sum_re = SW'(a_re_q) + t_re;
  assign sum_im = SW'(a_im_q) + t_im;
  assign dif_re = SW'(a_re_q) - t_re;
  assign dif_im = SW'(a_im_q) - t_im;

  assign top_re_o = DW'(sum_re >>> 1);
  assign top_im_o = DW'(sum_im >>> 1);
  assign bot_re_o = DW'(dif_re >>> 1);
  assign bot_im_o = DW'(dif_im >>> 1);

endmodule

// File: rtl/spin_table_1.sv
// Twiddle ROM: index k -> 127*e^(-j*2*pi*k/8), 12-bit signed parts.
module spin_table_1 (
  input  logic [2:0]         k_i,
  output logic signed [11:0] w_re_o,
  output logic signed [11:0] w_im_o
);

  // Constant lookup; 127*cos(pi/4) = 89.8 rounds to 90
  always_comb begin
    w_re_o = 12'sd127;
    w_im_o = 12'sd0;
    case (k_i)
      3'd0: begin w_re_o =  12'sd127; w_im_o =  12'sd0;   end
      3'd1: begin w_re_o =  12'sd90;  w_im_o = -12'sd90;  end
      3'd2: begin w_re_o =  12'sd0;   w_im_o = -12'sd127; end
      3'd3: begin w_re_o = -12'sd90;  w_im_o = -12'sd90;  end
      3'd4: begin w_re_o = -12'sd127; w_im_o =  12'sd0;   end
      3'd5: begin w_re_o = -12'sd90;  w_im_o =  12'sd90;  end
      3'd6: begin w_re_o =  12'sd0;   w_im_o =  12'sd127; end
      3'd7: begin w_re_o =  12'sd90;  w_im_o =  12'sd90;  end
      default: begin w_re_o = 12'sd127; w_im_o = 12'sd0; end
    endcase
  end

endmodule

// File: rtl/fft_core_1.sv
// 8-point radix-2 DIT FFT: stream in 8 real samples (bit-reversed into the
// register file), run 3 in-place stages at 2 cycles per butterfly, then
// stream out 8 complex bins in natural order through an output register.
module fft_core_1
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_re,
  output logic signed [DW-1:0] m_im,
  output logic [LOG2N-1:0]     m_idx,
  output logic                 m_last
);

  state_e               state_q, state_d;
  logic [LOG2N-1:0]     n_q, n_d;      // input sample counter
  logic [LOG2N-1:0]     u_q, u_d;      // next bin to read out
  logic [1:0]           s_q, s_d;      // stage
  logic [1:0]           j_q, j_d;      // butterfly within stage
  logic                 ph_q, ph_d;    // 0 = read phase, 1 = write phase
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic signed [DW-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
  logic [LOG2N-1:0]     m_idx_q, m_idx_d;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  logic [LOG2N-1:0]     top_addr, bot_addr, tw_k;
  logic signed [DW-1:0] w_re, w_im;
  logic signed [DW-1:0] y_top_re, y_top_im, y_bot_re, y_bot_im;
  logic                 s_fire, bfly_rd, bfly_wr;

  assign s_ready = (state_q == LOAD);
  assign s_fire  = s_valid && s_ready;
  assign bfly_rd = (state_q == CALC) && !ph_q;
  assign bfly_wr = (state_q == CALC) &&  ph_q;

  // Butterfly operand addresses and twiddle index for (stage, butterfly)
  always_comb begin
    top_addr = {j_q, 1'b0};
    bot_addr = {j_q, 1'b1};
    tw_k     = '0;
    case (s_q)
      2'd1: begin
        top_addr = {j_q[1], 1'b0, j_q[0]};
        bot_addr = {j_q[1], 1'b1, j_q[0]};
        tw_k     = {1'b0, j_q[0], 1'b0};
      end
      2'd2: begin
        top_addr = {1'b0, j_q};
        bot_addr = {1'b1, j_q};
        tw_k     = {1'b0, j_q};
      end
      default: begin
        top_addr = {j_q, 1'b0};
        bot_addr = {j_q, 1'b1};
        tw_k     = '0;
      end
    endcase
  end

  spin_table_1 u_spin (
    .k_i    (tw_k),
    .w_re_o (w_re),
    .w_im_o (w_im)
  );

  fft_bfly_1 u_bfly (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (bfly_rd),
    .a_re_i   (mem_re[top_addr]),
    .a_im_i   (mem_im[top_addr]),
    .b_re_i   (mem_re[bot_addr]),
    .b_im_i   (mem_im[bot_addr]),
    .w_re_i   (w_re),
    .w_im_i   (w_im),
    .top_re_o (y_top_re),
    .top_im_o (y_top_im),
    .bot_re_o (y_bot_re),
    .bot_im_o (y_bot_im)
  );

  // Register file writes: samples during LOAD, butterfly results in the write phase
  always_ff @(posedge clk) begin
    if (s_fire) begin
      mem_re[bitrev3(n_q)] <= s_data;
      mem_im[bitrev3(n_q)] <= '0;
    end else if (bfly_wr) begin
      mem_re[top_addr] <= y_top_re;
      mem_im[top_addr] <= y_top_im;
      mem_re[bot_addr] <= y_bot_re;
      mem_im[bot_addr] <= y_bot_im;
    end
  end

  // Next-state, counter and output-register logic
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    u_d       = u_q;
    s_d       = s_q;
    j_d       = j_q;
    ph_d      = ph_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    m_idx_d   = m_idx_q;
    case (state_q)
      LOAD: begin
        if (s_fire) begin
          n_d = n_q + 3'd1;
          if (n_q == 3'd7) state_d = CALC;
        end
      end
      CALC: begin
        ph_d = !ph_q;
        if (ph_q) begin
          j_d = j_q + 2'd1;
          if (j_q == 2'd3) begin
            s_d = s_q + 2'd1;
            if (s_q == 2'd2) begin
              s_d     = 2'd0;
              state_d = UNLOAD;
            end
          end
        end
      end
      UNLOAD: begin
        // Load a bin when the register is empty or its bin is being taken (not the last)
        if (!m_valid_q || (m_ready && !m_last_q)) begin
          m_valid_d = 1'b1;
          m_re_d    = mem_re[u_q];
          m_im_d    = mem_im[u_q];
          m_idx_d   = u_q;
          m_last_d  = (u_q == 3'd7);
          u_d       = u_q + 3'd1;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          u_d       = '0;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State, counters and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      n_q       <= '0;
      u_q       <= '0;
      s_q       <= '0;
      j_q       <= '0;
      ph_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      u_q       <= u_d;
      s_q       <= s_d;
      j_q       <= j_d;
      ph_q      <= ph_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_idx_q   <= m_idx_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_re    = m_re_q;
  assign m_im    = m_im_q;
  assign m_idx   = m_idx_q;

endmodule

// File: tb/tb_fft_core_1.sv
// Self-checking bench for fft_core_1: table of frames with hand-computed bins,
// plus backpressure, reset-in-CALC and reset-in-UNLOAD sequences.
module tb_fft_core_1;
  import fft_pkg::*;

  typedef int arr8_t [8];
  typedef struct {
    arr8_t x;
    arr8_t er;
    arr8_t ei;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [DW-1:0] m_re;
  logic signed [DW-1:0] m_im;
  logic [LOG2N-1:0]     m_idx;
  logic                 m_last;

  int    total = 0;
  int    bad   = 0;
  vec_t  vecs [4];
  arr8_t got_re, got_im, mod_re, mod_im, rx;

  always #5 clk = ~clk;

  fft_core_1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_idx   (m_idx),
    .m_last  (m_last)
  );

  task automatic check(input bit ok, input string what);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s", what);
    end
  endtask

  function automatic int wrap(input int v, input int bits);
    int m;
    m = v & ((1 << bits) - 1);
    if (m >= (1 << (bits - 1))) m = m - (1 << bits);
    return m;
  endfunction

  // Bit-exact reference: generic index formulas, twiddles 127*e^(-j*2*pi*k/8) rounded
  task automatic model(input arr8_t x);
    int re [8];
    int im [8];
    int wr [4];
    int wi [4];
    int span, top, bot, k, tr, ti, sr, si, dr, di;
    wr = '{127, 90, 0, -90};
    wi = '{0, -90, -127, -90};
    for (int n = 0; n < 8; n++) begin
      re[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)] = x[n];
      im[n] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 4; j++) begin
        span = 1 << s;
        top  = ((j >> s) << (s + 1)) | (j & (span - 1));
        bot  = top + span;
        k    = (j & (span - 1)) << (2 - s);
        tr   = wrap((re[bot] * wr[k] - im[bot] * wi[k]) >>> 7, 13);
        ti   = wrap((re[bot] * wi[k] + im[bot] * wr[k]) >>> 7, 13);
        sr   = wrap(re[top] + tr, 13);
        si   = wrap(im[top] + ti, 13);
        dr   = wrap(re[top] - tr, 13);
        di   = wrap(im[top] - ti, 13);
        re[top] = wrap(sr >>> 1, 12);
        im[top] = wrap(si >>> 1, 12);
        re[bot] = wrap(dr >>> 1, 12);
        im[bot] = wrap(di >>> 1, 12);
      end
    end
    for (int n = 0; n < 8; n++) begin
      mod_re[n] = re[n];
      mod_im[n] = im[n];
    end
  endtask

  // Push 8 samples; entered anywhere, leaves at the negedge after the 8th transfer
  task automatic send_frame(input arr8_t x, input bit gaps, input string tag);
    int i = 0;
    int cyc = 0;
    bit fire;
    @(negedge clk);
    while (i < 8 && cyc < 500) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_data  = 12'sh7FF;
      end else begin
        s_valid = 1'b1;
        s_data  = 12'(x[i]);
      end
      fire = s_valid && s_ready;
      @(negedge clk);
      if (fire) i++;
      cyc++;
    end
    s_valid = 1'b0;
    check(i == 8, $sformatf("%s in_count got=%0d want=8", tag, i));
    check(s_ready == 1'b0, $sformatf("%s s_ready_drop got=%0b want=0", tag, s_ready));
  endtask

  // Count cycles to first m_valid; optionally hold s_valid high with junk meanwhile
  task automatic wait_valid(input bit junk, input string tag);
    int cyc = 0;
    s_valid = junk;
    s_data  = 12'sh3C3;
    while (!m_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    check(cyc == 25, $sformatf("%s latency got=%0d want=25", tag, cyc));
  endtask

  // Collect nbins bins (at a negedge on entry), compare each transfer
  task automatic recv(input arr8_t er, input arr8_t ei, input int nbins, input bit bp,
                      input string tag);
    int b = 0;
    int cyc = 0;
    while (b < nbins && cyc < 1000) begin
      m_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_valid && m_ready) begin
        got_re[b] = int'(m_re);
        got_im[b] = int'(m_im);
        check(int'(m_re) == er[b] && int'(m_im) == ei[b] && int'(m_idx) == b &&
              m_last == (b == 7),
              $sformatf("%s bin%0d got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d last=%0b",
                        tag, b, m_re, m_im, m_idx, m_last, er[b], ei[b], b, (b == 7)));
        b++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    check(b == nbins && (bp || cyc == nbins),
          $sformatf("%s out_count got=%0d in %0d cycles want=%0d", tag, b, cyc, nbins));
    if (nbins == 8)
      check(s_ready == 1'b1 && m_valid == 1'b0,
            $sformatf("%s back_to_load got s_ready=%0b m_valid=%0b want 1/0", tag, s_ready, m_valid));
  endtask

  task automatic check_reset(input string tag);
    check(s_ready == 1'b1 && m_valid == 1'b0 && m_re == '0 && m_im == '0 &&
          m_idx == '0 && m_last == 1'b0,
          $sformatf("%s reset_vals got rdy=%0b vld=%0b re=%0d im=%0d idx=%0d last=%0b want 1/0/0/0/0/0",
                    tag, s_ready, m_valid, m_re, m_im, m_idx, m_last));
  endtask

  initial begin
    int d;
    bit ok;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // Impulse: every bin 256/8
    vecs[0].x  = '{256, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].er = '{32, 32, 32, 32, 32, 32, 32, 32};
    vecs[0].ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    // DC 128: stage gains 127/128 truncate 128 -> 127 -> 126 -> 125
    vecs[1].x  = '{128, 128, 128, 128, 128, 128, 128, 128};
    vecs[1].er = '{125, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    // Tone round(100*cos(2*pi*n/8)); floor shifts leave bin1=49, bin7=50, bin0=-1
    vecs[2].x  = '{100, 71, 0, -71, -100, -71, 0, 71};
    vecs[2].er = '{-1, 49, 0, 0, 0, 0, 0, 50};
    vecs[2].ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    // Extremes: reference model
    vecs[3].x  = '{2047, -2048, 2047, -2048, 2047, -2048, 2047, -2048};
    model(vecs[3].x);
    vecs[3].er = mod_re;
    vecs[3].ei = mod_im;

    @(negedge clk);
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].x, 1'b0, $sformatf("vec%0d", v));
      wait_valid(v == 1, $sformatf("vec%0d", v));
      recv(vecs[v].er, vecs[v].ei, 8, 1'b0, $sformatf("vec%0d", v));
      if (v == 2) begin
        d  = got_re[1] - got_re[7];
        ok = got_re[1] >= 40 && got_re[7] >= 40 && d <= 1 && d >= -1;
        for (int b = 0; b < 8; b++)
          if (b != 1 && b != 7 && (got_re[b] > 1 || got_re[b] < -1 ||
                                   got_im[b] > 1 || got_im[b] < -1)) ok = 1'b0;
        check(ok, $sformatf("tone_shape got bin1=%0d bin7=%0d want both>=40 within 1, others |v|<=1",
                            got_re[1], got_re[7]));
      end
    end

    // Backpressure: random samples, input gaps, random m_ready
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 8; n++) rx[n] = int'($urandom_range(0, 4095)) - 2048;
      model(rx);
      send_frame(rx, 1'b1, $sformatf("bp%0d", f));
      wait_valid(1'b0, $sformatf("bp%0d", f));
      recv(mod_re, mod_im, 8, 1'b1, $sformatf("bp%0d", f));
    end

    // Reset in the middle of CALC, then a clean tone frame
    send_frame(vecs[2].x, 1'b0, "rcalc_pre");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rcalc");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(vecs[2].x, 1'b0, "rcalc_post");
    wait_valid(1'b0, "rcalc_post");
    recv(vecs[2].er, vecs[2].ei, 8, 1'b0, "rcalc_post");

    // Reset after bin 3 has been taken, then a clean DC frame
    send_frame(vecs[0].x, 1'b0, "runl_pre");
    wait_valid(1'b0, "runl_pre");
    recv(vecs[0].er, vecs[0].ei, 4, 1'b0, "runl_pre");
    rst_n = 1'b0;
    #1;
    check_reset("runl");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(vecs[1].x, 1'b0, "runl_post");
    wait_valid(1'b0, "runl_post");
    recv(vecs[1].er, vecs[1].ei, 8, 1'b0, "runl_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
